// File: rtl/fuzz_seq_pkg.sv
// Shared types and MISR step function for the fuzz vector sequencer.
// Signatures up to MISR_MAX_W bits are supported by misr_step.
package fuzz_seq_pkg;

  localparam int MISR_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  // Caller zero-extends to MISR_MAX_W and truncates the result back to w bits.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input int unsigned           w,
    input int unsigned           tap
  );
    logic fb;
    fb = sig[w-1] ^ sig[tap];
    return ((sig << 1) | MISR_MAX_W'(fb)) ^ data;
  endfunction

endpackage

// File: rtl/fuzz_seq_misr.sv
// Multiple-input signature register folding DUT output into a signature.
// Single feedback tap: fb = sig[MSB] ^ sig[TAP].
module fuzz_seq_misr
  import fuzz_seq_pkg::*;
#(
  parameter int OUT_W = 240,
  parameter int TAP   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [OUT_W-1:0] data,
  output logic [OUT_W-1:0] sig
);

  logic [OUT_W-1:0] step;

  always_comb begin
    step = OUT_W'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(data), OUT_W, TAP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clear) begin
      sig <= '0;
    end else if (enable) begin
      sig <= step;
    end
  end

endmodule

// File: rtl/fuzz_vector_sequencer.sv
// Start/done controlled vector sequencer: ROM fetch, apply, settle, MISR capture.
// Optional FUZZ_SEQ_COMPARE_EN adds expected_sig/mismatch signature comparison.
module fuzz_vector_sequencer
  import fuzz_seq_pkg::*;
#(
  parameter int IN_W   = 76,
  parameter int OUT_W  = 240,
  parameter int VEC_W  = 256,
  parameter int ADDR_W = 5,
  parameter int SETTLE = 2,
  parameter int TAP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_vec,
  output logic              vec_rd,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [VEC_W-1:0]  vec_data,
  output logic [IN_W-1:0]   dut_in,
  input  logic [OUT_W-1:0]  dut_out,
  output logic              cap_valid,
  output logic [ADDR_W-1:0] cap_idx,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  signature
`ifdef FUZZ_SEQ_COMPARE_EN
  ,
  input  logic [OUT_W-1:0]  expected_sig,
  output logic              mismatch
`endif
);

  localparam int CW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SLAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  state_t          state;
  state_t          state_nxt;
  logic [ADDR_W:0] index;
  logic [ADDR_W:0] index_inc;
  logic [ADDR_W:0] num;
  logic [CW-1:0]   cnt;
  logic            start_ok;
  logic            last;

  generate
    if (VEC_W > IN_W) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^vec_data[VEC_W-1:IN_W];
    end
  endgenerate

  assign index_inc = index + 1'b1;
  assign last      = (index_inc == num);
  assign start_ok  = start && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = (num_vec == '0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: state_nxt = ST_APPLY;
      ST_APPLY: state_nxt = (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
      ST_SETTLE: begin
        if (cnt == CW'(SLAST)) state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: state_nxt = last ? ST_DONE : ST_FETCH;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index  <= '0;
      num    <= '0;
      cnt    <= '0;
      dut_in <= '0;
    end else begin
      if (start_ok) begin
        num    <= num_vec;
        index  <= '0;
        dut_in <= '0;
      end
      if (state == ST_APPLY) begin
        dut_in <= vec_data[IN_W-1:0];
        cnt    <= '0;
      end
      if (state == ST_SETTLE) cnt <= cnt + 1'b1;
      if (state == ST_CAPTURE) index <= index_inc;
    end
  end

  assign vec_rd    = (state == ST_FETCH);
  assign vec_addr  = vec_rd ? index[ADDR_W-1:0] : '0;
  assign cap_valid = (state == ST_CAPTURE);
  assign cap_idx   = cap_valid ? index[ADDR_W-1:0] : '0;
  assign busy      = (state == ST_FETCH) || (state == ST_APPLY) ||
                     (state == ST_SETTLE) || (state == ST_CAPTURE);
  assign done      = (state == ST_DONE);

  fuzz_seq_misr #(
    .OUT_W (OUT_W),
    .TAP   (TAP)
  ) u_misr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (start_ok),
    .enable (cap_valid),
    .data   (dut_out),
    .sig    (signature)
  );

`ifdef FUZZ_SEQ_COMPARE_EN
  // Signature value that will be held in DONE, known one cycle early.
  logic [OUT_W-1:0] fin_sig;
  logic             enter_done;

  always_comb begin
    fin_sig = '0;
    if (state == ST_CAPTURE) begin
      fin_sig = OUT_W'(misr_step(MISR_MAX_W'(signature),
                                 MISR_MAX_W'(dut_out), OUT_W, TAP));
    end
  end

  assign enter_done = (state_nxt == ST_DONE) &&
                      ((state != ST_DONE) || start_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch <= 1'b0;
    end else if (enter_done) begin
      mismatch <= (fin_sig != expected_sig);
    end else if (start_ok) begin
      mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fuzz_vector_sequencer.sv
// Scoreboard bench for fuzz_vector_sequencer: directed runs, ROM and DUT models.
// Define FUZZ_SEQ_COMPARE_EN to also exercise the signature comparator.
module tb_fuzz_vector_sequencer;

  localparam int IN_W   = 76;
  localparam int OUT_W  = 240;
  localparam int VEC_W  = 256;
  localparam int ADDR_W = 5;
  localparam int SETTLE = 2;
  localparam int TAP    = 2;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [ADDR_W:0]   num_vec;
  logic              vec_rd;
  logic [ADDR_W-1:0] vec_addr;
  logic [VEC_W-1:0]  vec_data;
  logic [IN_W-1:0]   dut_in;
  logic [OUT_W-1:0]  dut_out;
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_idx;
  logic              busy;
  logic              done;
  logic [OUT_W-1:0]  signature;
`ifdef FUZZ_SEQ_COMPARE_EN
  logic [OUT_W-1:0]  expected_sig;
  logic              mismatch;
`endif

  fuzz_vector_sequencer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .VEC_W  (VEC_W),
    .ADDR_W (ADDR_W),
    .SETTLE (SETTLE),
    .TAP    (TAP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_vec   (num_vec),
    .vec_rd    (vec_rd),
    .vec_addr  (vec_addr),
    .vec_data  (vec_data),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .cap_valid (cap_valid),
    .cap_idx   (cap_idx),
    .busy      (busy),
    .done      (done),
    .signature (signature)
`ifdef FUZZ_SEQ_COMPARE_EN
    ,
    .expected_sig (expected_sig),
    .mismatch     (mismatch)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [VEC_W-1:0] rom [0:(1<<ADDR_W)-1];
  logic             const_mode;

  always @(posedge clk) begin
    if (vec_rd) vec_data <= rom[vec_addr];
  end

  function automatic logic [OUT_W-1:0] dut_fn(input logic [IN_W-1:0] d);
    return {d, d, d, 12'hA5C};
  endfunction

  always_comb begin
    dut_out = const_mode ? OUT_W'(1) : dut_fn(dut_in);
  end

  function automatic logic [OUT_W-1:0] model_step(
    input logic [OUT_W-1:0] s,
    input logic [OUT_W-1:0] d
  );
    logic fb;
    fb = s[OUT_W-1] ^ s[TAP];
    return {s[OUT_W-2:0], fb} ^ d;
  endfunction

  function automatic logic [OUT_W-1:0] model_run(input int n);
    logic [OUT_W-1:0] s;
    logic [IN_W-1:0]  din;
    s = '0;
    for (int i = 0; i < n; i++) begin
      din = rom[i][IN_W-1:0];
      s = model_step(s, const_mode ? OUT_W'(1) : dut_fn(din));
    end
    return s;
  endfunction

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [IN_W-1:0]   din;
    logic [OUT_W-1:0]  sig;
  } exp_t;

  exp_t              q[$];
  int                total;
  int                bad;
  int                rd_cnt;
  int                cap_cnt;
  logic [ADDR_W-1:0] last_idx;

  task automatic chk(input string nm, input logic [OUT_W-1:0] got,
                     input logic [OUT_W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (vec_rd) begin
        chk("vec_addr", OUT_W'(vec_addr), OUT_W'(rd_cnt));
        rd_cnt++;
      end
      if (cap_valid) begin
        cap_cnt++;
        last_idx = cap_idx;
        if (q.size() == 0) begin
          chk("unexpected_cap", OUT_W'(cap_valid), '0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("cap_idx", OUT_W'(cap_idx), OUT_W'(e.idx));
          chk("cap_dut_in", OUT_W'(dut_in), OUT_W'(e.din));
          chk("cap_sig_pre", signature, e.sig);
        end
      end
    end
  end

  task automatic push_exp(input int n);
    logic [OUT_W-1:0] s;
    logic [IN_W-1:0]  din;
    s = '0;
    for (int i = 0; i < n; i++) begin
      din = rom[i][IN_W-1:0];
      q.push_back('{idx: ADDR_W'(i), din: din, sig: s});
      s = model_step(s, const_mode ? OUT_W'(1) : dut_fn(din));
    end
  endtask

  task automatic kick(input int n);
    rd_cnt  = 0;
    cap_cnt = 0;
    push_exp(n);
    @(posedge clk);
    #1;
    num_vec = (ADDR_W+1)'(n);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input int n, output logic [OUT_W-1:0] s);
    int k;
    int limit;
    s = model_run(n);
    kick(n);
    k = 0;
    limit = (SETTLE + 3) * n + 20;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) chk("vec_rd_first", OUT_W'(vec_rd), OUT_W'(n > 0));
    end while (!done && k < limit);
    chk("latency", OUT_W'(k), OUT_W'((SETTLE + 3) * n + 1));
    chk("rd_count", OUT_W'(rd_cnt), OUT_W'(n));
    chk("cap_count", OUT_W'(cap_cnt), OUT_W'(n));
    chk("signature", signature, s);
    chk("busy_in_done", OUT_W'(busy), '0);
    chk("queue_empty", OUT_W'(q.size()), '0);
    if (n > 0) begin
      chk("dut_in_hold", OUT_W'(dut_in), OUT_W'(rom[n-1][IN_W-1:0]));
      chk("last_idx", OUT_W'(last_idx), OUT_W'(n - 1));
    end
    q.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vec_rd"}, OUT_W'(vec_rd), '0);
    chk({nm, "_vec_addr"}, OUT_W'(vec_addr), '0);
    chk({nm, "_dut_in"}, OUT_W'(dut_in), '0);
    chk({nm, "_cap_valid"}, OUT_W'(cap_valid), '0);
    chk({nm, "_cap_idx"}, OUT_W'(cap_idx), '0);
    chk({nm, "_busy"}, OUT_W'(busy), '0);
    chk({nm, "_done"}, OUT_W'(done), '0);
    chk({nm, "_sig"}, signature, '0);
  endtask

  logic [OUT_W-1:0] g;
  logic [OUT_W-1:0] g5;

  initial begin
    total = 0;
    bad = 0;
    rd_cnt = 0;
    cap_cnt = 0;
    last_idx = '0;
    const_mode = 1'b1;
    start = 1'b0;
    num_vec = '0;
`ifdef FUZZ_SEQ_COMPARE_EN
    expected_sig = '0;
`endif
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      rom[i] = {8{32'(i) * 32'h9E3779B1 + 32'h01234567}};
    end
    rom[0] = VEC_W'(1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single vector, constant y = 1
    run(1, g);
    chk("t1_sig", signature, OUT_W'(1));

    // two vectors, constant y = 1
    run(2, g);
    chk("t2_sig", signature, OUT_W'(3));

    // empty run
    run(0, g);
    chk("t3_sig", signature, '0);

    // full ROM, data-dependent y
    const_mode = 1'b0;
    run(32, g);
    chk("t4_last_idx", OUT_W'(last_idx), OUT_W'(31));

    // reset during SETTLE of the third vector, then rerun
    run(5, g5);
    kick(5);
    for (int i = 0; i < 60 && cap_cnt < 2; i++) @(negedge clk);
    chk("t5_two_caps", OUT_W'(cap_cnt), OUT_W'(2));
    repeat (3) @(negedge clk);
    chk("t5_busy", OUT_W'(busy), OUT_W'(1));
    chk("t5_applied", OUT_W'(dut_in), OUT_W'(rom[2][IN_W-1:0]));
    rst_n = 1'b0;
    #1;
    chk_zero("t5_rst");
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(5, g);
    chk("t5_golden", signature, g5);

`ifdef FUZZ_SEQ_COMPARE_EN
    expected_sig = model_run(3);
    run(3, g);
    chk("t6_match", OUT_W'(mismatch), '0);
    expected_sig = model_run(3) ^ OUT_W'(1);
    run(3, g);
    chk("t6_mismatch", OUT_W'(mismatch), OUT_W'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
